regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file for the pipelined CPU; the next generation of the two-read/one-write file.
- Adds configurable data width and depth, N read and M write ports, and write-to-read bypass, which replaces the negedge "double bump" write.
- Adds a per-register busy scoreboard that the hazard unit uses for stall decisions.
- Sits between ID (reads, issue) and WB (writes).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W; entry 0 is hardwired to zero.
- NUM_RD, 2, number of read ports.
- NUM_WR, 2, number of write ports.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, combinational.
- rd_busy  out  NUM_RD  scoreboard busy flag of the addressed register, combinational.
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*ADDR_W  write addresses.
- wr_data  in  NUM_WR*DATA_W  write data.
- iss_en  in  1  issue strobe: marks iss_addr busy (pending writeback).
- iss_addr  in  ADDR_W  destination register of the issued instruction.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  DATA_W  stored value at dbg_addr; never bypassed.
- busy_vec  out  2**ADDR_W  full scoreboard, bit 0 always 0.

Behaviour:
- Reset (async, rst=1):
  - all entries 1..depth-1 and all busy bits cleared to 0 immediately, independent of clk;
  - writes and issues are ignored while rst is high;
  - consequently rd_data=0, rd_busy=0, dbg_data=0 and busy_vec=0 during reset, except for bypassed data when BYPASS=1.
- Write:
  - at posedge, for each port j with wr_en[j]=1 and wr_addr≠0, the entry takes wr_data[j];
  - if several ports target the same address in one cycle, the highest-index port wins;
  - a write to address 0 is discarded.
- Read (combinational, zero latency):
  - rd_addr=0 returns 0 and rd_busy=0;
  - with BYPASS=1: if any enabled write port targets rd_addr (≠0) this cycle, return the wr_data of the highest-index matching port, otherwise the stored value;
  - with BYPASS=0: always return the stored value; new data is visible from the cycle after the write.
- Scoreboard (posedge):
  - a write on any port to address a≠0 clears busy[a];
  - iss_en with iss_addr≠0 sets busy[iss_addr];
  - same-cycle issue and write to the same address leaves busy=1, because the new producer supersedes the old one;
  - iss_addr=0 has no effect.
- rd_busy[k] = busy[rd_addr[k]]. It reflects the registered state and is not bypassed: a register being written this cycle still reads busy until the next edge. The hazard unit combines rd_busy with the BYPASS match itself.
- Reset asserted mid-cycle discards any pending write or issue.
- rst deasserts synchronously to clk by design; the first edge after deassertion performs normal operations.

Decomposition:
- Shared package (cpu_pkg): DATA_W/ADDR_W defaults and the constant REG_ZERO = 0.
- One natural sub-module, regfile_scoreboard: holds the busy bits, issue/clear logic and busy_vec.
- The storage array and bypass muxes stay in regfile_mp.
- Port-priority selection is a generate loop, not a separate module.

Test Plan:
- Reset check: rst pulse with no clk -> all dbg_data reads return 0 and busy_vec=0. Write port0 r5=0xDEADBEEF, then assert rst asynchronously -> r5 reads 0 immediately.
- Basic write/read: port0 writes r3=0x12345678 -> next cycle rd_addr[0]=3 gives 0x12345678. Write r0=0xFFFFFFFF -> r0 still reads 0.
- Dual-write conflict: port0 r7=0x1111 and port1 r7=0x2222 in the same cycle -> r7=0x2222 stored. Same-cycle bypass read of r7 returns 0x2222 when BYPASS=1, and the old value when BYPASS=0.
- Bypass plus second read port: write r9=0xABCD while both read ports address r9 -> both give 0xABCD combinationally, dbg_data still shows the old r9.
- Scoreboard: issue r4 -> busy[4]=1 next cycle. Write r4 -> busy[4]=0. Issue r4 and write r4 in the same cycle -> busy[4] stays 1. Issue r0 -> busy_vec unchanged.
- Parameter sweep: NUM_RD=4, NUM_WR=3, DATA_W=64, ADDR_W=6 -> r63 writable, highest-index write port wins, all four read ports independent.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: default register-file geometry and the hardwired zero register.
package cpu_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback; issue beats a same-cycle writeback.
module regfile_scoreboard
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_WR = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic [2**ADDR_W-1:0]     busy_vec
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(i)) begin
                    busy_d[i] = 1'b0;
                end
            end
            // The newly issued producer supersedes whatever is writing back now.
            if (iss_en && iss_addr == ADDR_W'(i)) begin
                busy_d[i] = 1'b1;
            end
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with optional write-to-read bypass and a busy scoreboard for the hazard unit.
module regfile_mp
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic [ADDR_W-1:0]        dbg_addr,
    output logic [DATA_W-1:0]        dbg_data,
    output logic [2**ADDR_W-1:0]     busy_vec
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // Ports are scanned in ascending order so the highest-index writer lands last.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(i)) begin
                    mem_d[i] = wr_data[j*DATA_W +: DATA_W];
                end
            end
        end
        mem_d[REG_ZERO] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy_vec (busy_vec)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] ra;
            logic [DATA_W-1:0] rd_val;

            assign ra = rd_addr[gi*ADDR_W +: ADDR_W];

            always_comb begin
                rd_val = mem_q[ra];
                if (BYPASS != 0) begin
                    for (int j = 0; j < NUM_WR; j++) begin
                        if (wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] == ra) begin
                            rd_val = wr_data[j*DATA_W +: DATA_W];
                        end
                    end
                end
                if (ra == ADDR_W'(REG_ZERO)) begin
                    rd_val = '0;
                end
            end

            assign rd_data[gi*DATA_W +: DATA_W] = rd_val;
            // Busy is the registered state; the hazard unit folds in bypass itself.
            assign rd_busy[gi] = busy_vec[ra];
        end
    endgenerate

    assign dbg_data = mem_q[dbg_addr];
endmodule
